// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared parameters for the main-memory arbiter slice.
//   ADDR     - memory word-address width
//   WORD     - memory data width
//   STARVE_W - width of the instruction-port starvation counter
package mem_arbiter_pkg;
    localparam int ADDR     = 16;
    localparam int WORD     = 32;
    localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between the instruction and
// data requesters.
//   i_req, d_req - current requests
//   i_force      - (default build) instruction port must win this cycle
//   last_i       - (MEM_ARB_RR_EN build) instruction port won the last grant
//   i_win, d_win - selected winner, at most one high
// Optional feature macro: MEM_ARB_RR_EN selects alternating priority.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_i,
`else
    input  logic i_force,
`endif
    output logic i_win,
    output logic d_win
);
    logic i_pri;

`ifdef MEM_ARB_RR_EN
    // The port that did not win last time gets priority on contention.
    assign i_pri = ~last_i;
`else
    assign i_pri = i_force;
`endif

    always_comb begin
        i_win = i_req & (~d_req | i_pri);
        d_win = d_req & ~i_win;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of the single-port main memory.
// Instruction fetch (read only) and data load/store share the memory port;
// one grant per cycle, read data returned to the issuing port one cycle later.
//   clk, rst                      - clock, synchronous active-high reset
//   i_req/i_addr/i_gnt            - instruction request handshake
//   i_rvalid/i_rdata              - instruction read response
//   d_req/d_we/d_addr/d_wdata     - data request
//   d_gnt/d_rvalid/d_rdata        - data grant and read response
//   mem_A/mem_W/mem_D/mem_Q       - memory port (mem_Q is registered read data)
// Optional feature macro: MEM_ARB_RR_EN (alternating priority instead of
// fixed data priority with starvation counter).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    output logic [ADDR-1:0] mem_A,
    output logic            mem_W,
    output logic [WORD-1:0] mem_D,
    input  logic [WORD-1:0] mem_Q
);
    logic            i_win, d_win;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            rd_i_q, rd_i_d;
    logic            rd_d_q, rd_d_d;

`ifdef MEM_ARB_RR_EN
    logic last_i_q, last_i_d;

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_i (last_i_q),
        .i_win  (i_win),
        .d_win  (d_win)
    );

    always_comb begin
        last_i_d = last_i_q;
        if (i_gnt)      last_i_d = 1'b1;
        else if (d_gnt) last_i_d = 1'b0;
    end
`else
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                i_force;

    assign i_force = (starve_q == STARVE_W'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .i_force (i_force),
        .i_win   (i_win),
        .d_win   (d_win)
    );

    // Counts consecutive cycles the instruction port is waiting.
    always_comb begin
        starve_d = '0;
        if (i_req && !i_gnt) starve_d = starve_q + 1'b1;
    end
`endif

    // Grants are suppressed while reset is high so nothing reaches memory.
    assign i_gnt = i_win & ~rst;
    assign d_gnt = d_win & ~rst;

    // Address/data are combinational in the grant cycle and held otherwise.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (i_gnt) begin
            addr_d = i_addr;
        end else if (d_gnt) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
        end
        rd_i_d = i_gnt;
        rd_d_d = d_gnt & ~d_we;
    end

    assign mem_A    = addr_d;
    assign mem_D    = wdata_d;
    assign mem_W    = d_gnt & d_we;
    assign i_rvalid = rd_i_q;
    assign d_rvalid = rd_d_q;
    assign i_rdata  = mem_Q;
    assign d_rdata  = mem_Q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_i_q   <= 1'b0;
            rd_d_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_i_q <= 1'b1;
`else
            starve_q <= '0;
`endif
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_i_q   <= rd_i_d;
            rd_d_q   <= rd_d_d;
`ifdef MEM_ARB_RR_EN
            last_i_q <= last_i_d;
`else
            starve_q <= starve_d;
`endif
        end
    end
endmodule
